// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO: pointers, occupancy, almost/sticky-error flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int ADD_WIDTH  = 3,
  parameter int AFULL_THR  = 6,
  parameter int AEMPTY_THR = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd_en,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADD_WIDTH:0]    count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADD_WIDTH:0] AF_T =
    (ADD_WIDTH+1)'(AFULL_THR);
  localparam logic [ADD_WIDTH:0] AE_T =
    (ADD_WIDTH+1)'(AEMPTY_THR);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADD_WIDTH:0]    wr_ptr;
  logic [ADD_WIDTH:0]    rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADD_WIDTH] != rd_ptr[ADD_WIDTH]) &&
                 (wr_ptr[ADD_WIDTH-1:0] == rd_ptr[ADD_WIDTH-1:0]);
  assign almost_full  = (count >= AF_T);
  assign almost_empty = (count <= AE_T);

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_ff @(posedge CLK) begin
    if (wr_acc)
      mem[wr_ptr[ADD_WIDTH-1:0]] <= wdata;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // A fresh error in the clearing cycle keeps its flag set.
  always_ff @(posedge CLK) begin
    if (RST) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en & full)       overflow <= 1'b1;
      else if (clr_err)       overflow <= 1'b0;
      if (rd_en & empty)      underflow <= 1'b1;
      else if (clr_err)       underflow <= 1'b0;
    end
  end

`ifdef FIFO_FWFT_EN
  assign rdata  = mem[rd_ptr[ADD_WIDTH-1:0]];
  assign rvalid = ~empty;
`else
  always_ff @(posedge CLK) begin
    if (RST) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_acc;
      if (rd_acc)
        rdata <= mem[rd_ptr[ADD_WIDTH-1:0]];
    end
  end
`endif

endmodule
